// File: rtl/vram_arbiter_pkg.sv
// vram_arbiter_pkg: VRAM slot phases, table field widths and slot strobe bundle
package vram_arbiter_pkg;
  localparam int VRAM_AW = 14;
  localparam int NB_W = 4;
  localparam int PB_W = 3;
  localparam int CB_W = 6;
  localparam logic [3:0] PH_NAME = 4'd0;
  localparam logic [3:0] PH_PAT = 4'd2;
  localparam logic [3:0] PH_COL = 4'd4;
  localparam logic [3:0] PH_XFER = 4'd15;
  typedef struct packed {
    logic ph_name;
    logic ph_pat;
    logic ph_col;
    logic rsv_name;
    logic rsv_pat;
    logic rsv_col;
    logic rsv;
    logic cap_name;
    logic cap_pat;
    logic cap_col;
    logic xfer;
  } slot_t;
endpackage

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: CPU-side VRAM port, req held until ack, reads return one cycle later
interface vram_arbiter_if
  import vram_arbiter_pkg::*;
#(
  parameter int AW = VRAM_AW
) ();
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [7:0]    wdata;
  logic          ack;
  logic [7:0]    rdata;
  logic          rvalid;
  modport master (output req, we, addr, wdata, input ack, rdata, rvalid);
  modport slave (input req, we, addr, wdata, output ack, rdata, rvalid);
endinterface

// File: rtl/vram_arbiter_slot_decode.sv
// vram_arbiter_slot_decode: tile phase and fetch enable to reserved-read and capture strobes
module vram_arbiter_slot_decode
  import vram_arbiter_pkg::*;
(
  input  logic [3:0] i_phase,
  input  logic       i_fetch_en,
  output slot_t      o_slot
);
  logic w_name, w_pat, w_col;
  assign w_name = i_phase == PH_NAME;
  assign w_pat = i_phase == PH_PAT;
  assign w_col = i_phase == PH_COL;
  // each capture lands one cycle after its read, matching the RAM's read latency
  assign o_slot = '{
    ph_name:  w_name,
    ph_pat:   w_pat,
    ph_col:   w_col,
    rsv_name: i_fetch_en && w_name,
    rsv_pat:  i_fetch_en && w_pat,
    rsv_col:  i_fetch_en && w_col,
    rsv:      i_fetch_en && (w_name || w_pat || w_col),
    cap_name: i_phase == PH_NAME + 4'd1,
    cap_pat:  i_phase == PH_PAT + 4'd1,
    cap_col:  i_phase == PH_COL + 4'd1,
    xfer:     i_phase == PH_XFER
  };
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: fixed-slot renderer fetches with double-buffered tile bytes;
// every other RAM cycle goes to the CPU req/ack port.
module vram_arbiter #(
  parameter int VRAM_AW = 14
) (
  input  logic                             pxclk,
  input  logic                             reset,
  input  logic [3:0]                       i_phase,
  input  logic                             i_fetch_en,
  input  logic [4:0]                       i_tile_col,
  input  logic [4:0]                       i_tile_row,
  input  logic [2:0]                       i_line,
  input  logic [vram_arbiter_pkg::NB_W-1:0] i_name_base,
  input  logic [vram_arbiter_pkg::PB_W-1:0] i_pattern_base,
  input  logic [vram_arbiter_pkg::CB_W-1:0] i_colour_base,
  output logic [7:0]                       o_pattern_q,
  output logic [7:0]                       o_colour_q,
  vram_arbiter_if.slave                    cpu,
  output logic [VRAM_AW-1:0]               o_ram_addr,
  output logic                             o_ram_we,
  output logic [7:0]                       o_ram_wdata,
  input  logic [7:0]                       i_ram_rdata
);
  import vram_arbiter_pkg::*;
  slot_t      w_slot;
  logic       w_ack, w_rvalid;
  logic [7:0] r_name, r_pat, r_col, r_pattern_q, r_colour_q, r_rdata;
  logic       r_complete, r_rpend;
  vram_arbiter_slot_decode u_slot (
    .i_phase    (i_phase),
    .i_fetch_en (i_fetch_en),
    .o_slot     (w_slot)
  );
  assign w_ack = cpu.req && !w_slot.rsv && !reset;
  assign w_rvalid = r_rpend && !reset;
  assign cpu.ack = w_ack;
  assign cpu.rvalid = w_rvalid;
  // read data is forwarded straight from RAM in the rvalid cycle and held after
  assign cpu.rdata = w_rvalid ? i_ram_rdata : r_rdata;
  assign o_ram_we = w_ack && cpu.we;
  assign o_ram_wdata = cpu.wdata;
  assign o_ram_addr = w_slot.rsv_name ? {i_name_base, i_tile_row, i_tile_col} :
                      w_slot.rsv_pat  ? {i_pattern_base, r_name, i_line} :
                      w_slot.rsv_col  ? {i_colour_base, r_name} : cpu.addr;
  assign o_pattern_q = r_pattern_q;
  assign o_colour_q = r_colour_q;
  always_ff @(posedge pxclk)
    if (reset) begin
      r_name <= '0;
      r_pat <= '0;
      r_col <= '0;
      r_complete <= 1'b0;
      r_pattern_q <= '0;
      r_colour_q <= '0;
      r_rdata <= '0;
      r_rpend <= 1'b0;
    end else begin
      r_rpend <= w_ack && !cpu.we;
      if (w_rvalid) r_rdata <= i_ram_rdata;
      if (w_slot.cap_name) r_name <= i_ram_rdata;
      if (w_slot.cap_pat) r_pat <= i_ram_rdata;
      if (w_slot.cap_col) r_col <= i_ram_rdata;
      r_complete <= w_slot.ph_name ? i_fetch_en :
                    (w_slot.ph_pat || w_slot.ph_col) ? r_complete && i_fetch_en : r_complete;
      if (w_slot.xfer && r_complete) begin
        r_pattern_q <= r_pat;
        r_colour_q <= r_col;
      end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed and randomized checks of vram_arbiter against a tile-level memory model
module tb_vram_arbiter;
  logic        pxclk = 1'b0;
  logic        reset;
  logic [3:0]  ph;
  logic        fen;
  logic [4:0]  tcol, trow;
  logic [2:0]  ln;
  logic [3:0]  nb;
  logic [2:0]  pb;
  logic [5:0]  cb;
  logic [7:0]  pattern_q, colour_q, ram_wdata, ram_rdata;
  logic [13:0] ram_addr;
  logic        ram_we;
  logic [7:0]  mem [16384];
  int          vectors = 0;
  int          miscompares = 0;
  int          acks, mode;
  logic        m_pend, m_ok;
  logic [7:0]  m_pdata, m_held, m_name, m_pat, m_col, m_pq, m_cq;
  logic        last_ack, last_we, last_rvalid;
  logic [13:0] last_addr;
  logic [7:0]  last_rdata;

  vram_arbiter_if cpu_if ();

  vram_arbiter #(.VRAM_AW(14)) dut (
    .pxclk          (pxclk),
    .reset          (reset),
    .i_phase        (ph),
    .i_fetch_en     (fen),
    .i_tile_col     (tcol),
    .i_tile_row     (trow),
    .i_line         (ln),
    .i_name_base    (nb),
    .i_pattern_base (pb),
    .i_colour_base  (cb),
    .o_pattern_q    (pattern_q),
    .o_colour_q     (colour_q),
    .cpu            (cpu_if),
    .o_ram_addr     (ram_addr),
    .o_ram_we       (ram_we),
    .o_ram_wdata    (ram_wdata),
    .i_ram_rdata    (ram_rdata)
  );

  always #5 pxclk = ~pxclk;

  // single-port synchronous RAM, read-before-write
  always @(posedge pxclk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we) mem[ram_addr] = ram_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one pxclk cycle: inputs already driven at the falling edge
  task automatic cyc();
    logic rsv, eack, erv;
    logic [13:0] eaddr;
    #1;
    rsv = fen && (ph == 4'd0 || ph == 4'd2 || ph == 4'd4);
    eack = cpu_if.req && !rsv && !reset;
    erv = m_pend && !reset;
    eaddr = !rsv ? cpu_if.addr : ph == 4'd0 ? {nb, trow, tcol} :
            ph == 4'd2 ? {pb, m_name, ln} : {cb, m_name};
    chk("cpu_ack", cpu_if.ack, eack);
    chk("ram_we", ram_we, eack && cpu_if.we);
    chk("ram_addr", ram_addr, eaddr);
    if (eack && cpu_if.we) chk("ram_wdata", ram_wdata, cpu_if.wdata);
    chk("cpu_rvalid", cpu_if.rvalid, erv);
    chk("cpu_rdata", cpu_if.rdata, erv ? m_pdata : m_held);
    chk("pattern_q", pattern_q, m_pq);
    chk("colour_q", colour_q, m_cq);
    last_ack = cpu_if.ack;
    last_we = ram_we;
    last_addr = ram_addr;
    last_rvalid = cpu_if.rvalid;
    last_rdata = cpu_if.rdata;
    if (reset) begin
      {m_pend, m_ok} = '0;
      {m_pdata, m_held, m_name, m_pat, m_col, m_pq, m_cq} = '0;
    end else begin
      if (erv) m_held = m_pdata;
      m_pend = eack && !cpu_if.we;
      m_pdata = mem[cpu_if.addr];
      if (ph == 4'd0) begin
        m_ok = fen;
        m_name = mem[eaddr];
      end
      if (ph == 4'd2) begin
        m_ok = m_ok && fen;
        m_pat = mem[eaddr];
      end
      if (ph == 4'd4) begin
        m_ok = m_ok && fen;
        m_col = mem[eaddr];
      end
      if (ph == 4'd15 && m_ok) begin
        m_pq = m_pat;
        m_cq = m_col;
      end
    end
    @(posedge pxclk);
    @(negedge pxclk);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'($urandom);
    reset = 1'b1;
    {ph, fen, tcol, trow, ln, nb, pb, cb} = '0;
    cpu_if.req = 1'b0;
    cpu_if.we = 1'b0;
    cpu_if.addr = '0;
    cpu_if.wdata = '0;
    {m_pend, m_ok} = '0;
    {m_pdata, m_held, m_name, m_pat, m_col, m_pq, m_cq} = '0;
    @(posedge pxclk);
    @(negedge pxclk);
    cyc();
    reset = 1'b0;
    ph = 4'd0;
    cyc();
    chk("idle_pattern_q", pattern_q, 8'h00);
    chk("idle_colour_q", colour_q, 8'h00);
    chk("idle_rdata", cpu_if.rdata, 8'h00);
    chk("idle_rvalid", cpu_if.rvalid, 1'b0);
    chk("idle_ack", cpu_if.ack, 1'b0);
    chk("idle_ram_we", ram_we, 1'b0);
    // CPU write with the renderer idle
    ph = 4'd1;
    cpu_if.req = 1'b1;
    cpu_if.we = 1'b1;
    cpu_if.addr = 14'h1234;
    cpu_if.wdata = 8'h5A;
    cyc();
    chk("wr_ack", last_ack, 1'b1);
    chk("wr_ram_we", last_we, 1'b1);
    chk("wr_ram_addr", last_addr, 14'h1234);
    cpu_if.req = 1'b0;
    chk("wr_mem", mem[14'h1234], 8'h5A);
    for (int p = 2; p < 16; p++) begin
      ph = 4'(p);
      cyc();
    end
    // full renderer fetch of one tile
    mem[14'h0443] = 8'h21;
    mem[14'h090D] = 8'hA5;
    mem[14'h0321] = 8'hF4;
    mem[14'h0100] = 8'h77;
    nb = 4'd1;
    trow = 5'd2;
    tcol = 5'd3;
    pb = 3'd1;
    ln = 3'd5;
    cb = 6'd3;
    fen = 1'b1;
    for (int p = 0; p < 16; p++) begin
      ph = 4'(p);
      cyc();
    end
    chk("fetch_pattern_q", pattern_q, 8'hA5);
    chk("fetch_colour_q", colour_q, 8'hF4);
    // CPU read contending with the name slot
    for (int p = 0; p < 16; p++) begin
      ph = 4'(p);
      if (p == 0) begin
        cpu_if.req = 1'b1;
        cpu_if.we = 1'b0;
        cpu_if.addr = 14'h0100;
      end
      cyc();
      if (p == 0) chk("rd_blocked", last_ack, 1'b0);
      if (p == 1) begin
        chk("rd_ack", last_ack, 1'b1);
        cpu_if.req = 1'b0;
      end
      if (p == 2) begin
        chk("rd_rvalid", last_rvalid, 1'b1);
        chk("rd_rdata", last_rdata, 8'h77);
      end
    end
    chk("rd_tile_pattern_q", pattern_q, 8'hA5);
    chk("rd_tile_colour_q", colour_q, 8'hF4);
    // bandwidth with a permanently pending CPU
    cpu_if.req = 1'b1;
    cpu_if.we = 1'b0;
    for (int t = 0; t < 18; t++) begin
      fen = t < 16;
      acks = 0;
      for (int p = 0; p < 16; p++) begin
        ph = 4'(p);
        cyc();
        acks += int'(last_ack);
        if (last_ack) cpu_if.addr = 14'($urandom);
        if (fen && (p == 0 || p == 2 || p == 4)) chk("bw_rsv_slot", last_ack, 1'b0);
      end
      chk("bw_acks", acks, fen ? 13 : 16);
    end
    cpu_if.req = 1'b0;
    // fetch_en dropped mid-tile: outputs must hold
    mem[14'h090D] = 8'h3C;
    mem[14'h0321] = 8'h11;
    for (int p = 0; p < 16; p++) begin
      ph = 4'(p);
      fen = p < 3;
      cpu_if.req = p == 4;
      cyc();
      if (p == 4) chk("drop_ack_ph4", last_ack, 1'b1);
    end
    cpu_if.req = 1'b0;
    chk("drop_pattern_q", pattern_q, 8'hA5);
    chk("drop_colour_q", colour_q, 8'hF4);
    // reset the cycle after a read ack
    fen = 1'b0;
    ph = 4'd0;
    cpu_if.req = 1'b1;
    cpu_if.we = 1'b0;
    cpu_if.addr = 14'h0100;
    cyc();
    chk("rst_rd_ack", last_ack, 1'b1);
    cpu_if.req = 1'b0;
    ph = 4'd1;
    reset = 1'b1;
    cyc();
    chk("rst_no_rvalid", last_rvalid, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_pattern_q", pattern_q, 8'h00);
    chk("rst_colour_q", colour_q, 8'h00);
    chk("rst_rdata", cpu_if.rdata, 8'h00);
    chk("rst_rvalid", cpu_if.rvalid, 1'b0);
    chk("rst_ram_we", ram_we, 1'b0);
    // randomized tiles
    last_ack = 1'b1;
    for (int t = 0; t < 40; t++) begin
      mode = $urandom_range(0, 3);
      nb = 4'($urandom);
      pb = 3'($urandom);
      cb = 6'($urandom);
      ln = 3'($urandom);
      tcol = 5'($urandom);
      trow = 5'($urandom);
      for (int p = 0; p < 16; p++) begin
        ph = 4'(p);
        fen = mode == 2 ? 1'b0 : mode == 3 ? 1'($urandom) : 1'b1;
        if (!cpu_if.req || last_ack) begin
          cpu_if.req = $urandom_range(0, 2) != 0;
          cpu_if.we = 1'($urandom);
          cpu_if.addr = 14'($urandom);
          cpu_if.wdata = 8'($urandom);
        end
        cyc();
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
